// File: rtl/comparator_pkg.sv
// Shared types for the pipelined comparator: lane compare result encoding and counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: cmp_res_t (per-lane result), CNT_W (delivered-beat counter width).
package comparator_pkg;

  // EQ is the all-zero code, so an idle lane never reads as GT or LT.
  typedef enum logic [1:0] {
    CMP_EQ = 2'b00,
    CMP_LT = 2'b01,
    CMP_GT = 2'b10
  } cmp_res_t;

  localparam int CNT_W = 16;

endpackage

// File: rtl/cmp_lane.sv
// Single-lane magnitude compare of A against B, signed or unsigned.
// Latency: combinational, 0 cycles.
// Backpressure: none (pure function of its inputs).
// Ports: a, b (WIDTH-bit operands), is_signed (1 = two's complement), res (cmp_res_t).
module cmp_lane
  import comparator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output cmp_res_t         res
);

  // Flipping the sign bit maps two's-complement order onto unsigned order,
  // so one unsigned comparator serves both modes (WIDTH=1: 1 -> -1 < 0).
  logic [WIDTH-1:0] a_k;
  logic [WIDTH-1:0] b_k;

  always_comb begin
    a_k = a;
    b_k = b;
    if (is_signed) begin
      a_k[WIDTH-1] = ~a[WIDTH-1];
      b_k[WIDTH-1] = ~b[WIDTH-1];
    end
  end

  always_comb begin
    if (a_k > b_k) begin
      res = CMP_GT;
    end else if (a_k < b_k) begin
      res = CMP_LT;
    end else begin
      res = CMP_EQ;
    end
  end

endmodule

// File: rtl/pipelined_comparator.sv
// Multi-lane registered comparator: one-hot GT/LT/EQ per lane plus all-lanes-equal, valid/ready streamed.
// Latency: 1 cycle from accept to out_valid; full throughput of 1 beat per cycle.
// Backpressure: in_ready = !out_valid || out_ready; results held stable while out_valid && !out_ready.
// Ports: clk, rst (async active-high); in_valid/in_ready/in_signed/in_a/in_b; out_valid/out_ready;
//        out_gt/out_lt/out_eq (CHANNELS each), out_all_eq.
// Option PIPELINED_COMPARATOR_STICKY_EN adds sticky_clr, sticky_gt, sticky_lt, beat_count.
module pipelined_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_signed,
  input  logic [CHANNELS*WIDTH-1:0] in_a,
  input  logic [CHANNELS*WIDTH-1:0] in_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS-1:0]       out_gt,
  output logic [CHANNELS-1:0]       out_lt,
  output logic [CHANNELS-1:0]       out_eq,
  output logic                      out_all_eq
`ifdef PIPELINED_COMPARATOR_STICKY_EN
  ,
  input  logic                      sticky_clr,
  output logic [CHANNELS-1:0]       sticky_gt,
  output logic [CHANNELS-1:0]       sticky_lt,
  output logic [CNT_W-1:0]          beat_count
`endif
);

  cmp_res_t            lane_res [CHANNELS];
  logic [CHANNELS-1:0] gt_next;
  logic [CHANNELS-1:0] lt_next;
  logic [CHANNELS-1:0] eq_next;
  logic                accept;
  logic                drain;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    cmp_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .a        (in_a[i*WIDTH +: WIDTH]),
      .b        (in_b[i*WIDTH +: WIDTH]),
      .is_signed(in_signed),
      .res      (lane_res[i])
    );
  end

  always_comb begin
    gt_next = '0;
    lt_next = '0;
    eq_next = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      gt_next[i] = (lane_res[i] == CMP_GT);
      lt_next[i] = (lane_res[i] == CMP_LT);
      eq_next[i] = (lane_res[i] == CMP_EQ);
    end
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;

  // Result registers only load on accept, so undriven operands on idle
  // cycles never reach the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_gt     <= '0;
      out_lt     <= '0;
      out_eq     <= '0;
      out_all_eq <= 1'b0;
    end else begin
      if (accept) begin
        out_valid  <= 1'b1;
        out_gt     <= gt_next;
        out_lt     <= lt_next;
        out_eq     <= eq_next;
        out_all_eq <= &eq_next;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef PIPELINED_COMPARATOR_STICKY_EN
  // Sticky flags and counter track delivered results; clear wins over a
  // same-cycle handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_gt  <= '0;
      sticky_lt  <= '0;
      beat_count <= '0;
    end else if (sticky_clr) begin
      sticky_gt  <= '0;
      sticky_lt  <= '0;
      beat_count <= '0;
    end else if (drain) begin
      sticky_gt <= sticky_gt | out_gt;
      sticky_lt <= sticky_lt | out_lt;
      if (beat_count != {CNT_W{1'b1}}) begin
        beat_count <= beat_count + 1'b1;
      end
    end
  end
`endif

endmodule
